// File: rtl/sample_packer.sv
// Packs 4-bit samples LSB-first into 16-bit words and queues them in a DEPTH-word FIFO.
// Optional per-word parity output is enabled with the SAMPLE_PACKER_PARITY_EN macro.
module sample_packer #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [3:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        overflow,
`ifdef SAMPLE_PACKER_PARITY_EN
    output logic        out_parity,
`endif
    output logic [7:0]  drop_count
);

    localparam int PW = $clog2(DEPTH);

    logic [1:0]    r_slot;
    logic [11:0]   r_partial;
    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          r_overflow;
    logic [7:0]    r_drop_count;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_push_ok;
    logic          w_drop;
    logic          w_out_valid;
    logic [15:0]   w_word;

    // The word completes on the edge that takes sample 3, so it goes straight to the FIFO.
    assign w_word      = {in_data, r_partial};
    assign w_push      = in_valid & ~clear & (r_slot == 2'd3);
    assign w_out_valid = (r_count != '0);
    assign w_full      = (r_count == (PW + 1)'(DEPTH));
    assign w_pop       = w_out_valid & out_ready & ~clear;
    assign w_push_ok   = w_push & (~w_full | w_pop);
    assign w_drop      = w_push & w_full & ~w_pop;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_slot    <= 2'd0;
            r_partial <= 12'h000;
        end else if (in_valid) begin
            r_slot <= r_slot + 2'd1;
            case (r_slot)
                2'd0:    r_partial[3:0]  <= in_data;
                2'd1:    r_partial[7:4]  <= in_data;
                2'd2:    r_partial[11:8] <= in_data;
                default: r_partial       <= 12'h000;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_word;
    end

    // Storage is not reset; the empty-gating below keeps out_data at zero after clear.
    assign out_valid  = w_out_valid;
    assign out_data   = w_out_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

`ifdef SAMPLE_PACKER_PARITY_EN
    logic r_par [DEPTH];

    always_ff @(posedge clock) begin
        if (w_push_ok) r_par[r_wr_ptr] <= ^w_word;
    end

    assign out_parity = w_out_valid ? r_par[r_rd_ptr] : 1'b0;
`endif

endmodule

// File: tb/tb_sample_packer.sv
// Self-checking bench for sample_packer: queue-based word model plus directed literal checks.
module tb_sample_packer;

    localparam int DEPTH = 4;

    logic        clock;
    logic        clear;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        overflow;
    logic [7:0]  drop_count;
`ifdef SAMPLE_PACKER_PARITY_EN
    logic        out_parity;
`endif

    int checks   = 0;
    int failures = 0;

    sample_packer #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .overflow   (overflow),
`ifdef SAMPLE_PACKER_PARITY_EN
        .out_parity (out_parity),
`endif
        .drop_count (drop_count)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // model: word queue, partial word, drop bookkeeping
    logic [15:0] exp_q[$];
    logic [15:0] m_word    = 16'h0000;
    int          m_slot    = 0;
    int          m_drops   = 0;
    bit          m_ovf     = 1'b0;
    bit          m_started = 1'b0;

    always @(posedge clock) begin
        bit do_pop;
        if (clear) begin
            exp_q.delete();
            m_word    = 16'h0000;
            m_slot    = 0;
            m_drops   = 0;
            m_ovf     = 1'b0;
            m_started = 1'b1;
        end else begin
            do_pop = (exp_q.size() != 0) && out_ready;
            if (do_pop) void'(exp_q.pop_front());
            if (in_valid) begin
                m_word = m_word | (16'(in_data) << (4 * m_slot));
                if (m_slot == 3) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(m_word);
                    else begin
                        m_ovf = 1'b1;
                        if (m_drops < 255) m_drops++;
                    end
                    m_word = 16'h0000;
                    m_slot = 0;
                end else begin
                    m_slot++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard compare on the falling edge
    always @(negedge clock) begin
        if (m_started) begin
            chk("cmp_out_valid", 16'(out_valid), 16'(exp_q.size() != 0));
            chk("cmp_out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : 16'h0000);
            chk("cmp_overflow", 16'(overflow), 16'(m_ovf));
            chk("cmp_drop_count", 16'(drop_count), 16'(m_drops));
`ifdef SAMPLE_PACKER_PARITY_EN
            chk("cmp_out_parity", 16'(out_parity), (exp_q.size() != 0) ? 16'(^exp_q[0]) : 16'h0000);
`endif
        end
    end

    // driver tasks
    task automatic step(input logic v, input logic [3:0] d, input logic rdy);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w, input logic rdy);
        for (int i = 0; i < 4; i++) step(1'b1, w[4*i +: 4], rdy);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1'b1, 4'hF, 1'b1);
        clear = 1'b0;
    endtask

    initial begin
        clear     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b0;
        #2;
        do_clear();
        chk("reset_out_valid", 16'(out_valid), 16'h0);
        chk("reset_out_data", out_data, 16'h0000);
        chk("reset_overflow", 16'(overflow), 16'h0);
        chk("reset_drop_count", 16'(drop_count), 16'h0);

        // 1,2,3,4 -> 4321
        step(1'b1, 4'h1, 1'b0);
        step(1'b1, 4'h2, 1'b0);
        step(1'b1, 4'h3, 1'b0);
        chk("no_word_before_sample3", 16'(out_valid), 16'h0);
        step(1'b1, 4'h4, 1'b0);
        chk("word1_valid", 16'(out_valid), 16'h1);
        chk("word1_data", out_data, 16'h4321);
        step(1'b0, 4'h0, 1'b0);
        chk("stall_stable", out_data, 16'h4321);
        step(1'b0, 4'h0, 1'b1);
        chk("word1_popped", 16'(out_valid), 16'h0);
        step(1'b0, 4'h0, 1'b1);
        chk("empty_pop_noop", 16'(out_valid), 16'h0);

        // A,B gap C,D -> DCBA
        step(1'b1, 4'hA, 1'b0);
        step(1'b1, 4'hB, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'h7, 1'b0);
            chk("gap_no_word", 16'(out_valid), 16'h0);
        end
        step(1'b1, 4'hC, 1'b0);
        step(1'b1, 4'hD, 1'b0);
        chk("gap_word_data", out_data, 16'hDCBA);
        step(1'b0, 4'h0, 1'b1);

        // overflow: 6 words into a 4-deep FIFO
        for (int k = 1; k <= 6; k++) push_word(16'h1111 * 16'(k), 1'b0);
        chk("ovf_flag", 16'(overflow), 16'h1);
        chk("ovf_drop_count", 16'(drop_count), 16'd2);
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_pop_order", out_data, 16'h1111 * 16'(k));
            step(1'b0, 4'h0, 1'b1);
        end
        chk("ovf_drained", 16'(out_valid), 16'h0);

        // full FIFO, push and pop on the same edge
        for (int k = 1; k <= 4; k++) push_word(16'h1111 * 16'(k), 1'b0);
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'h5, 1'b1);
        chk("fullpp_drop_count", 16'(drop_count), 16'd2);
        chk("fullpp_head", out_data, 16'h2222);
        for (int k = 2; k <= 5; k++) begin
            chk("fullpp_order", out_data, 16'h1111 * 16'(k));
            step(1'b0, 4'h0, 1'b1);
        end
        chk("fullpp_drained", 16'(out_valid), 16'h0);

        // clear in mid-word
        step(1'b1, 4'h9, 1'b0);
        step(1'b1, 4'h9, 1'b0);
        do_clear();
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'h6, 1'b0);
        step(1'b1, 4'h7, 1'b0);
        step(1'b1, 4'h8, 1'b0);
        chk("midclear_data", out_data, 16'h8765);
        chk("midclear_overflow", 16'(overflow), 16'h0);
        chk("midclear_drop_count", 16'(drop_count), 16'h0);

        // drop_count saturation
        for (int k = 0; k < 262; k++) push_word(16'($urandom_range(0, 16'hFFFF)), 1'b0);
        chk("sat_drop_count", 16'(drop_count), 16'd255);
        push_word(16'h0F0F, 1'b0);
        chk("sat_hold", 16'(drop_count), 16'd255);
        do_clear();
        chk("sat_cleared", 16'(drop_count), 16'h0);

`ifdef SAMPLE_PACKER_PARITY_EN
        push_word(16'h0001, 1'b0);
        chk("parity_0001", 16'(out_parity), 16'h1);
        step(1'b0, 4'h0, 1'b1);
        chk("parity_empty", 16'(out_parity), 16'h0);
        push_word(16'h0003, 1'b0);
        chk("parity_0003", 16'(out_parity), 16'h0);
        step(1'b0, 4'h0, 1'b1);
`endif

        step(1'b0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
